ram_port_arbiter: RTL

//  Shares one single-read-port RAM (sync write, 1-cycle registered read) between NUM_REQ requesters.

---
 rtl/ram_port_arbiter_pkg.sv | 14 +
 rtl/rr_priority_pick.sv | 37 +++
 rtl/ram_port_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the RAM port arbiter: FSM encodings and default widths.
package ram_port_arbiter_pkg;

  localparam int unsigned DEF_NUM_REQ    = 4;
  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_ADDR_WIDTH = 13;
  localparam int unsigned DEF_MAX_BURST  = 8;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin priority pick: the first set req bit at or above ptr, wrapping
// from N-1 back to 0.
// Ports:
//   req     - request vector
//   ptr     - highest-priority index this cycle
//   grant_c - one-hot winner (all zero when no request)
//   id_c    - encoded winner index (0 when no request)
module rr_priority_pick #(
  parameter int unsigned N        = 4,
  parameter int unsigned ID_WIDTH = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]        req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [N-1:0]        grant_c,
  output logic [ID_WIDTH-1:0] id_c
);

  logic        found;
  int unsigned idx;

  // Scan N positions starting at ptr and keep the first hit.
  always_comb begin
    grant_c = '0;
    id_c    = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr) + k) % N;
      if (!found && req[ID_WIDTH'(idx)]) begin
        found                      = 1'b1;
        grant_c[ID_WIDTH'(idx)]    = 1'b1;
        id_c                       = ID_WIDTH'(idx);
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-read-port RAM (sync write, 1-cycle registered read)
// between NUM_REQ requesters. One access per cycle, round-robin, with
// optional locked bursts of up to MAX_BURST beats.
// Ports:
//   Clock, Reset           - clock; asynchronous active-low reset
//   iReq/iWe/iLock         - per-requester valid, write-enable, burst lock
//   iAddr/iData            - flattened per-requester address / write data
//   oGrant                 - one-hot access accepted this cycle (combinational)
//   oRdValid/oRdData       - read return, one cycle after the read grant
//   oRamWe/oRamAddr/oRamWData - RAM control (combinational)
//   iRamRData              - RAM registered read data
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned MAX_BURST  = DEF_MAX_BURST
) (
  input  logic                             Clock,
  input  logic                             Reset,
  input  logic [NUM_REQ-1:0]               iReq,
  input  logic [NUM_REQ-1:0]               iWe,
  input  logic [NUM_REQ-1:0]               iLock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    iAddr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    iData,
  output logic [NUM_REQ-1:0]               oGrant,
  output logic [NUM_REQ-1:0]               oRdValid,
  output logic [DATA_WIDTH-1:0]            oRdData,
  output logic                             oRamWe,
  output logic [ADDR_WIDTH-1:0]            oRamAddr,
  output logic [DATA_WIDTH-1:0]            oRamWData,
  input  logic [DATA_WIDTH-1:0]            iRamRData
);

  localparam int unsigned ID_WIDTH   = $clog2(NUM_REQ);
  localparam int unsigned BEAT_WIDTH = $clog2(MAX_BURST + 1);

  arb_state_e              state_q, state_d;
  logic [ID_WIDTH-1:0]     ptr_q, ptr_d;
  logic [ID_WIDTH-1:0]     owner_q, owner_d;
  logic [BEAT_WIDTH-1:0]   beats_q, beats_d;
  logic [NUM_REQ-1:0]      rd_valid_q, rd_valid_d;

  logic [NUM_REQ-1:0]      pick_req_c;
  logic [NUM_REQ-1:0]      pick_grant_c;
  logic [ID_WIDTH-1:0]     pick_id_c;
  logic [NUM_REQ-1:0]      grant_c;
  logic                    granted_c;
  logic                    we_c;
  logic                    lock_c;
  logic [ADDR_WIDTH-1:0]   addr_c;
  logic [DATA_WIDTH-1:0]   wdata_c;

  // Next pointer after id, wrapping at NUM_REQ.
  function automatic logic [ID_WIDTH-1:0] wrap_inc(input logic [ID_WIDTH-1:0] v);
    if (32'(v) == NUM_REQ - 1) return '0;
    return v + ID_WIDTH'(1);
  endfunction

  // While locked, only the owner is visible to the picker.
  always_comb begin
    pick_req_c = iReq;
    if (state_q == ARB_LOCKED) pick_req_c = iReq & (NUM_REQ'(1) << owner_q);
  end

  rr_priority_pick #(
    .N        (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .req     (pick_req_c),
    .ptr     (ptr_q),
    .grant_c (pick_grant_c),
    .id_c    (pick_id_c)
  );

  // Grants are suppressed while reset is held.
  assign grant_c   = Reset ? pick_grant_c : '0;
  assign granted_c = |grant_c;

  // One-hot mux of the winner's request fields onto the RAM port.
  always_comb begin
    we_c    = 1'b0;
    lock_c  = 1'b0;
    addr_c  = '0;
    wdata_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_c[i]) begin
        we_c    = iWe[i];
        lock_c  = iLock[i];
        addr_c  = iAddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        wdata_c = iData[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Arbitration FSM next-state and read-return pipeline input.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    beats_d    = beats_q;
    rd_valid_d = grant_c & ~iWe;
    case (state_q)
      ARB_IDLE: begin
        if (granted_c) begin
          if (lock_c && (MAX_BURST > 1)) begin
            state_d = ARB_LOCKED;
            owner_d = pick_id_c;
            beats_d = BEAT_WIDTH'(1);
          end else begin
            ptr_d = wrap_inc(pick_id_c);
          end
        end
      end
      ARB_LOCKED: begin
        // No grant while locked means the owner dropped its request.
        if (!granted_c) begin
          state_d = ARB_IDLE;
          ptr_d   = wrap_inc(owner_q);
          beats_d = '0;
        end else begin
          beats_d = beats_q + BEAT_WIDTH'(1);
          if (!lock_c || (beats_d >= BEAT_WIDTH'(MAX_BURST))) begin
            state_d = ARB_IDLE;
            ptr_d   = wrap_inc(owner_q);
            beats_d = '0;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= ARB_IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      beats_q    <= '0;
      rd_valid_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      beats_q    <= beats_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign oGrant    = grant_c;
  assign oRamWe    = we_c;
  assign oRamAddr  = addr_c;
  assign oRamWData = wdata_c;
  assign oRdValid  = rd_valid_q;
  assign oRdData   = iRamRData;

endmodule
